mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core. It replaces the single-cycle combinational decoder.
- Sequences the shared ALU, unified instruction/data memory, IR, register file and PC over 3-5 cycles per instruction.
- Stalls on a memory-ready handshake.
- Counts retired instructions and traps on illegal encodings.

Parameters:
COUNT_W, 16, width of retired-instruction counter (wraps modulo 2^COUNT_W)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
opcode  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, same cycle as ALU operation
mem_ready  input  1  memory completes current access this cycle
pc_en  output  1  PC register load enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  IR load enable
reg_dst  output  1  write register select: 0=rt, 1=rd
mem_to_reg  output  1  write data select: 0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=regA
alu_src_b  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_control  output  3  000 and, 001 or, 010 add, 110 sub, 111 slt
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal  output  1  high while in TRAP
state  output  4  current state encoding, debug
instr_count  output  COUNT_W  retired instruction count

Behaviour:
- Reset (async, rst_n low): state=FETCH (0), instr_count=0. Outputs take FETCH decode with mem_ready=0, i.e. all enables 0, alu_control=010, alu_src_b=01.
- Outputs are combinational from registered state, plus mem_ready/zero/funct where stated. Any output not listed for a state is 0, except alu_control which defaults to 010.
- Decoded opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- R-type funct mapping: 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111.
- States, their outputs and next state:
  - 0 FETCH: alu_src_b=01, add. ir_write=pc_en=mem_ready. Stay while !mem_ready; ->DECODE when ready.
  - 1 DECODE: alu_src_b=11, add.
    - lw/sw ->MEMADR
    - R with legal funct ->EXECUTE
    - beq ->BRANCH
    - addi ->ADDIEX
    - j ->JUMP
    - anything else, including R with unknown funct ->TRAP
  - 2 MEMADR: alu_src_a=1, alu_src_b=10, add. lw ->MEMRD, sw ->MEMWR.
  - 3 MEMRD: iord=1. Stay until mem_ready, then ->MEMWB.
  - 4 MEMWB: mem_to_reg=1, reg_write=1 ->FETCH.
  - 5 MEMWR: iord=1, mem_write=1, held until mem_ready. ->FETCH on ready.
  - 6 EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct ->ALUWB.
  - 7 ALUWB: reg_dst=1, reg_write=1 ->FETCH.
  - 8 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero ->FETCH.
  - 9 ADDIEX: alu_src_a=1, alu_src_b=10, add ->ADDIWB.
  - 10 ADDIWB: reg_write=1 ->FETCH.
  - 11 JUMP: pc_src=10, pc_en=1 ->FETCH.
  - 12 TRAP: illegal=1, all enables 0. Absorbing until reset.
  - 13-15: unreachable; if entered, ->FETCH next cycle with outputs as in TRAP.
- Retirement: instr_count increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH (taken or not), ADDIWB, JUMP, and leaving MEMWR with mem_ready=1. At all-ones it wraps to 0. TRAP does not count.
- CPI: R/addi=4, beq/j=3, sw=4, lw=5, each plus memory wait cycles (mem_ready=0 in FETCH/MEMRD/MEMWR).
- Reset mid-operation (any state, including a stalled memory access): immediate return to FETCH and instr_count=0. mem_write drops asynchronously.
- opcode/funct are sampled only in DECODE and EXECUTE; changes elsewhere have no effect.

Test Plan:
- Reset, then mem_ready=1 constant, R add (opcode 0, funct 100000) -> states 0,1,6,7,0. alu_control=010 in EXECUTE, reg_dst=1/reg_write=1 in ALUWB, instr_count=1 after 4 cycles.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> ir_write/pc_en pulse only on the ready cycle. 10 cycles total, then mem_to_reg=reg_write=1 for exactly one cycle.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01 for the first, pc_en=0 for the second. instr_count increments by 2.
- sw with mem_ready=0 for 2 MEMWR cycles -> mem_write=1 and iord=1 held 3 cycles, no reg_write, count+1.
- Opcode 111111 and R funct 000001 -> TRAP after DECODE, illegal=1, enables 0. instr_count frozen; state stays 12 for 20 cycles.
- Assert rst_n low mid-MEMWR stall -> state=0, mem_write=0, instr_count=0 without a clock edge. Next j (000010) after release -> JUMP with pc_en=1, pc_src=10.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences PC, memory, IR,
// register file and shared ALU, counts retired instructions, traps on bad encodings.
module mips_multicycle_ctrl #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] next_state;
  logic       retire;
  logic       is_sw;
  logic [2:0] r_alu;
  logic       r_legal;

  // R-type funct to ALU operation
  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_legal = 1'b0;
    endcase
  end

  // Next state, retirement strobe and per-state control outputs
  always_comb begin
    next_state  = state;
    retire      = 1'b0;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = r_legal ? S_EXECUTE : S_TRAP;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        next_state = S_TRAP;
      end
      default: begin
        illegal    = 1'b1;
        next_state = S_FETCH;
      end
    endcase
  end

  // lw/sw choice is captured in DECODE so MEMADR does not depend on opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      instr_count <= '0;
      is_sw       <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
      if (state == S_DECODE) is_sw <= (opcode == OP_SW);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench for mips_multicycle_ctrl: a per-instruction
// cycle-sequence model feeds an expected-output queue drained by a monitor.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [3:0]    st;
    logic          pc_en;
    logic          iord;
    logic          mem_write;
    logic          ir_write;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          reg_write;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_control;
    logic [1:0]    pc_src;
    logic          illegal;
    logic [CW-1:0] cnt;
  } exp_t;

  localparam logic [5:0] FN_LIST [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [2:0] AL_LIST [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  localparam logic [5:0] OP_LIST [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, pc_src;
  logic [2:0]    alu_control;
  logic          illegal;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;

  mips_multicycle_ctrl #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (FN_LIST[i] == fn) return AL_LIST[i];
    return 3'b010;
  endfunction

  // Expected control word for one cycle spent in step st of an instruction
  function automatic exp_t model(int st, bit mr, bit z, logic [5:0] fn, int c);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    e.alu_control = 3'b010;
    e.cnt = CW'(c);
    case (st)
      0:  begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      1:  e.alu_src_b = 2'b11;
      2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
      6:  begin e.alu_src_a = 1'b1; e.alu_control = alu_of(fn); end
      7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      8:  begin e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
      9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      10: e.reg_write = 1'b1;
      11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic cyc(input int st, input bit mr, input bit ret);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero = 1'($urandom);
    q.push_back(model(st, mr, zero, funct, cnt));
    if (ret) cnt = (cnt + 1) % (1 << CW);
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    int w;
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      cyc(0, 1'b0, 1'b0);
    end
    opcode = 6'($urandom); funct = 6'($urandom);
    cyc(0, 1'b1, 1'b0);
    opcode = op; funct = fn;
    cyc(1, 1'($urandom), 1'b0);
  endtask

  task automatic mem_wait(input int st, input bit ret);
    int w;
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) cyc(st, 1'b0, 1'b0);
    cyc(st, 1'b1, ret);
  endtask

  // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j
  task automatic run_instr(input int kind);
    logic [5:0] fn;
    fn = (kind == 0) ? FN_LIST[$urandom_range(0, 4)] : 6'($urandom);
    fetch_decode(OP_LIST[kind], fn);
    case (kind)
      0: begin cyc(6, 1'($urandom), 1'b0); cyc(7, 1'($urandom), 1'b1); end
      1: begin cyc(2, 1'($urandom), 1'b0); mem_wait(3, 1'b0); cyc(4, 1'($urandom), 1'b1); end
      2: begin cyc(2, 1'($urandom), 1'b0); mem_wait(5, 1'b1); end
      3: cyc(8, 1'($urandom), 1'b1);
      4: begin cyc(9, 1'($urandom), 1'b0); cyc(10, 1'($urandom), 1'b1); end
      default: cyc(11, 1'($urandom), 1'b1);
    endcase
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
    fetch_decode(op, fn);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      cyc(12, 1'($urandom), 1'b0);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous reset checked before any clock edge can intervene
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset state", int'(state), 0);
    chk("reset mem_write", int'(mem_write), 0);
    chk("reset instr_count", int'(instr_count), 0);
    chk("reset enables", int'({pc_en, ir_write, reg_write, iord, illegal}), 0);
    chk("reset alu_control", int'(alu_control), 2);
    chk("reset alu_src_b", int'(alu_src_b), 1);
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (rst_n === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      a = '{state, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_control, pc_src, illegal, instr_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle step=%0d at %0t: got %h expected %h (state %0d cnt %0d)",
                 e.st, $time, a, e, a.st, a.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    for (int k = 0; k < 6; k++) run_instr(k);
    repeat (150) run_instr($urandom_range(0, 5));
    run_illegal(6'b111111, 6'($urandom));
    do_reset();

    repeat (40) run_instr($urandom_range(0, 5));
    run_illegal(6'b000000, 6'b000001);
    do_reset();

    // store stalled in its write phase, then reset in the middle of the stall
    fetch_decode(OP_LIST[2], 6'($urandom));
    cyc(2, 1'b1, 1'b0);
    cyc(5, 1'b0, 1'b0);
    cyc(5, 1'b0, 1'b0);
    do_reset();
    run_instr(5);
    repeat (40) run_instr($urandom_range(0, 5));

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
